symbol_demap_controller: RTL and testbench
==========================================

SYMBOL_DEMAP_CONTROLLER -- requirements
Module: symbol_demap_controller

Interface
REQ-001 SHALL have parameter N, default 8, the number of coefficients per frame (N >= 1).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the width of each signed two's-complement coefficient.
REQ-003 SHALL have parameter THRESHOLD, default 192, the signed decision constant (1.5 in the solver fixed-point format).
REQ-004 SHALL have parameter ERASE_MARGIN, default 32, the half-width of the erasure band (used only under REQ-023).
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  a coefficient frame is offered.
REQ-008 SHALL have port in_ready  output  1  the block accepts a frame this cycle.
REQ-009 SHALL have port in_coefs  input  DATA_WIDTH*N  the frame; coefficient i occupies bits [N*DW-i*DW-1 : N*DW-(i+1)*DW] (i=0 at the MSB end).
REQ-010 SHALL have port out_valid  output  1  a decoded bit word is available.
REQ-011 SHALL have port out_ready  input  1  the consumer takes the word.
REQ-012 SHALL have port out_bits  output  N  decoded bits; out_bits[i] belongs to coefficient i.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> DEMAP -> DONE -> IDLE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL, on in_valid & in_ready, register the whole of in_coefs into a frame buffer, clear the index counter to 0 and move to DEMAP.
REQ-016 SHALL, in DEMAP, slice one coefficient per cycle, in index order 0..N-1, using one shared slicer; bit = 1 iff coefficient > THRESHOLD (signed compare); equality gives 0.
REQ-017 SHALL write each slice result to out_bits[idx]; leave DEMAP for DONE on the cycle that slices idx = N-1; the counter does not wrap.
REQ-018 SHALL give latency: handshake at cycle t -> out_valid high at cycle t+N+1.
REQ-019 SHALL, in DONE, hold out_bits stable until out_valid & out_ready, then return to IDLE; in_ready is high on the following cycle (no same-cycle accept).
REQ-020 SHALL ignore in_valid and in_coefs outside IDLE; a held frame is never overwritten mid-operation.
REQ-021 SHALL work for N = 1 (DEMAP lasts exactly one cycle) and size the index counter as max(1, clog2(N)) bits.

Reset
REQ-022 SHALL, on rst, at any time including mid-DEMAP or DONE, force state IDLE, counter 0, frame buffer 0, out_bits 0, out_valid 0, busy 0, in_ready 1 (the in-flight frame is discarded).

Configuration
REQ-023 SHALL, with macro SYMBOL_DEMAP_ERASURE_EN defined, add output out_erase [N] (reset 0), where out_erase[i] = 1 iff |coef_i - THRESHOLD| <= ERASE_MARGIN, computed in the same DEMAP cycle as out_bits[i] and held in DONE.
REQ-024 SHALL, without SYMBOL_DEMAP_ERASURE_EN, omit port out_erase and all margin logic; all other behaviour is identical.

Structure
REQ-025 SHALL place the FSM state encoding (IDLE, DEMAP, DONE) and the default THRESHOLD / ERASE_MARGIN constants in shared package demap_pkg.
REQ-026 SHALL instantiate one combinational sub-module threshold_slicer (one coefficient in; bit out, plus erasure flag when enabled).

Verification
REQ-027 SHALL cover N=4, coefs {200, 100, 193, -5} -> out_bits = 4'b0101 (bit0=1, bit1=0, bit2=1, bit3=0), out_valid at t+5.
REQ-028 SHALL cover boundary coef = 192 -> bit 0; coef = 193 -> bit 1; coef = -32768 -> bit 0.
REQ-029 SHALL cover out_ready held low for 10 cycles in DONE -> out_bits stable, in_ready low, a new in_valid frame is not accepted.
REQ-030 SHALL cover rst asserted at cycle t+2 of DEMAP -> next cycle state IDLE, out_valid 0, in_ready 1; the next frame decodes correctly.
REQ-031 SHALL cover back-to-back frames with in_valid held high -> second accept exactly one cycle after the out handshake.
REQ-032 SHALL cover, with SYMBOL_DEMAP_ERASURE_EN, coefs {224, 160, 225, 159} -> out_erase = 4'b0011 (bit0=1, bit1=1, bit2=0, bit3=0).

Source files
------------

// File: rtl/symbol_demap_controller_pkg.sv
// Shared FSM encoding, default decision constants and sizing helper for symbol_demap_controller.
package demap_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DEMAP = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_THRESHOLD    = 192;
   localparam int DEF_ERASE_MARGIN = 32;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/symbol_demap_controller_threshold_slicer.sv
// Combinational hard-decision slicer for one signed coefficient.
// With SYMBOL_DEMAP_ERASURE_EN defined it also flags coefficients within ERASE_MARGIN of THRESHOLD.
module threshold_slicer
   import demap_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int THRESHOLD    = DEF_THRESHOLD
`ifdef SYMBOL_DEMAP_ERASURE_EN
   ,
   parameter int ERASE_MARGIN = DEF_ERASE_MARGIN
`endif
) (
   input  logic [DATA_WIDTH-1:0] coef,
   output logic                  decision
`ifdef SYMBOL_DEMAP_ERASURE_EN
   ,
   output logic                  erase
`endif
);

   // Two guard bits keep coef - THRESHOLD and its magnitude from overflowing.
   localparam int EW = DATA_WIDTH + 2;
   localparam logic signed [EW-1:0] THR = EW'(THRESHOLD);

   logic signed [EW-1:0] coef_ext;

   assign coef_ext = {{2{coef[DATA_WIDTH-1]}}, coef};
   assign decision = (coef_ext > THR);

`ifdef SYMBOL_DEMAP_ERASURE_EN
   localparam logic signed [EW-1:0] MARGIN = EW'(ERASE_MARGIN);

   logic signed [EW-1:0] diff;
   logic signed [EW-1:0] dist;

   assign diff  = coef_ext - THR;
   assign dist  = diff[EW-1] ? -diff : diff;
   assign erase = (dist <= MARGIN);
`endif

endmodule

// File: rtl/symbol_demap_controller.sv
// Frame-based symbol demapper: accepts N coefficients, slices one per cycle, presents the bit word.
// Optional erasure output enabled by defining SYMBOL_DEMAP_ERASURE_EN.
module symbol_demap_controller
   import demap_pkg::*;
#(
   parameter int N            = 8,
   parameter int DATA_WIDTH   = 16,
   parameter int THRESHOLD    = DEF_THRESHOLD,
   parameter int ERASE_MARGIN = DEF_ERASE_MARGIN
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH*N-1:0] in_coefs,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N-1:0]            out_bits,
   output logic                    busy
`ifdef SYMBOL_DEMAP_ERASURE_EN
   ,
   output logic [N-1:0]            out_erase
`endif
);

   localparam int IW = idx_width(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   if (N < 1 || DATA_WIDTH < 2 || ERASE_MARGIN < 0) begin : g_param_check
      $error("symbol_demap_controller: invalid parameterisation");
   end

   state_t                  state;
   state_t                  next_state;
   logic [DATA_WIDTH*N-1:0] frame;
   logic [IW-1:0]           idx;
   logic [DATA_WIDTH-1:0]   coef_sel;
   logic                    decision;
`ifdef SYMBOL_DEMAP_ERASURE_EN
   logic                    erase_bit;
`endif

   // Coefficient 0 sits at the MSB end of the frame.
   always_comb begin
      coef_sel = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (idx == IW'(i)) begin
            coef_sel = frame[DATA_WIDTH*(N-i)-1 -: DATA_WIDTH];
         end
      end
   end

   threshold_slicer #(
      .DATA_WIDTH   (DATA_WIDTH),
      .THRESHOLD    (THRESHOLD)
`ifdef SYMBOL_DEMAP_ERASURE_EN
      ,
      .ERASE_MARGIN (ERASE_MARGIN)
`endif
   ) u_slicer (
      .coef     (coef_sel),
      .decision (decision)
`ifdef SYMBOL_DEMAP_ERASURE_EN
      ,
      .erase    (erase_bit)
`endif
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               next_state = DEMAP;
            end
         end
         DEMAP: begin
            if (idx == LAST) begin
               next_state = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame     <= '0;
         idx       <= '0;
         out_bits  <= '0;
`ifdef SYMBOL_DEMAP_ERASURE_EN
         out_erase <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  frame <= in_coefs;
                  idx   <= '0;
               end
            end
            DEMAP: begin
               for (int unsigned i = 0; i < N; i++) begin
                  if (idx == IW'(i)) begin
                     out_bits[i]  <= decision;
`ifdef SYMBOL_DEMAP_ERASURE_EN
                     out_erase[i] <= erase_bit;
`endif
                  end
               end
               // Counter parks on the last index; it is re-cleared on the next accept.
               if (idx != LAST) begin
                  idx <= idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_symbol_demap_controller.sv
// Randomised and directed bench for symbol_demap_controller (N=4) with a cycle-level reference model.
module tb_symbol_demap_controller;

   localparam int N      = 4;
   localparam int DW     = 16;
   localparam int THR    = 192;
   localparam int MARGIN = 32;

   logic            clk       = 1'b0;
   logic            rst       = 1'b1;
   logic            in_valid  = 1'b0;
   logic            out_ready = 1'b0;
   logic [N*DW-1:0] in_coefs  = '0;
   logic            in_ready;
   logic            out_valid;
   logic            busy;
   logic [N-1:0]    out_bits;
`ifdef SYMBOL_DEMAP_ERASURE_EN
   logic [N-1:0]    out_erase;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int cycle       = 0;

   symbol_demap_controller #(
      .N            (N),
      .DATA_WIDTH   (DW),
      .THRESHOLD    (THR),
      .ERASE_MARGIN (MARGIN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_coefs  (in_coefs),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bits  (out_bits),
      .busy      (busy)
`ifdef SYMBOL_DEMAP_ERASURE_EN
      ,
      .out_erase (out_erase)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [N*DW-1:0] pack(input int c0, input int c1, input int c2, input int c3);
      return {DW'(c0), DW'(c1), DW'(c2), DW'(c3)};
   endfunction

   // Reference model: a frame is held from accept until its word is taken; the word
   // becomes visible N clock edges after the accepting edge.
   bit           m_busy  = 1'b0;
   int           m_age   = 0;
   logic [N-1:0] m_bits  = '0;
   logic [N-1:0] m_erase = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0;
         m_age  = 0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy = 1'b1;
            m_age  = 0;
            for (int i = 0; i < N; i++) begin
               int c;
               c = int'($signed(in_coefs[(N-i)*DW-1 -: DW]));
               m_bits[i]  = (c > THR);
               m_erase[i] = ((c - THR) <= MARGIN) && ((THR - c) <= MARGIN);
            end
         end
      end else if (m_age == N) begin
         if (out_ready) m_busy = 1'b0;
      end else begin
         m_age++;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         check("rst_in_ready",  32'(in_ready),  32'd1);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_busy",      32'(busy),      32'd0);
         check("rst_out_bits",  32'(out_bits),  32'd0);
`ifdef SYMBOL_DEMAP_ERASURE_EN
         check("rst_out_erase", 32'(out_erase), 32'd0);
`endif
      end else begin
         check("in_ready",  32'(in_ready),  32'(!m_busy));
         check("out_valid", 32'(out_valid), 32'(m_busy && m_age == N));
         check("busy",      32'(busy),      32'(m_busy));
         if (m_busy && m_age == N) begin
            check("out_bits", 32'(out_bits), 32'(m_bits));
`ifdef SYMBOL_DEMAP_ERASURE_EN
            check("out_erase", 32'(out_erase), 32'(m_erase));
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input logic [N*DW-1:0] frame, input int hold,
                            input logic [N-1:0] exp_bits, input logic [N-1:0] exp_erase,
                            input string name);
      int waited;
      in_coefs = frame;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 50) begin
         step();
         waited++;
      end
      if (!in_ready) begin
         check({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      step();
      in_valid = 1'b0;
      waited   = 0;
      while (!out_valid && waited < 50) begin
         step();
         waited++;
      end
      check({name, "_latency"}, 32'(waited), 32'(N));
      check({name, "_bits"}, 32'(out_bits), 32'(exp_bits));
`ifdef SYMBOL_DEMAP_ERASURE_EN
      check({name, "_erase"}, 32'(out_erase), 32'(exp_erase));
`else
      if (exp_erase === 'x) $display("note: erase literal unused");
`endif
      for (int k = 0; k < hold; k++) begin
         in_valid = 1'b1;
         in_coefs = pack(1000, 1000, 1000, 1000);
         step();
         check({name, "_hold_bits"},     32'(out_bits),  32'(exp_bits));
         check({name, "_hold_in_ready"}, 32'(in_ready),  32'd0);
         check({name, "_hold_valid"},    32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      int c1;
      int c2;
      int waited;

      repeat (3) @(posedge clk);
      #1;
      check("init_in_ready",  32'(in_ready),  32'd1);
      check("init_out_valid", 32'(out_valid), 32'd0);
      check("init_busy",      32'(busy),      32'd0);
      check("init_out_bits",  32'(out_bits),  32'd0);
      rst = 1'b0;
      step();

      run_frame(pack(200, 100, 193, -5),        0,  4'b0101, 4'b0101, "basic");
      run_frame(pack(192, 193, -32768, 32767),  2,  4'b1010, 4'b0011, "boundary");
      run_frame(pack(224, 160, 225, 159),       10, 4'b0101, 4'b0011, "erase_band");

      // Reset two cycles into DEMAP discards the frame.
      in_coefs = pack(300, 0, 300, 0);
      in_valid = 1'b1;
      check("pre_rst_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      check("midrst_busy",      32'(busy),      32'd0);
      step();
      rst = 1'b0;
      run_frame(pack(-1, 1000, 192, 500), 0, 4'b1010, 4'b0100, "post_rst");

      // Back-to-back frames with in_valid and out_ready held high.
      in_coefs  = pack(200, 200, 0, 0);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      waited    = 0;
      while (!out_valid && waited < 50) begin
         step();
         waited++;
      end
      c1 = cycle;
      step();
      waited = 0;
      while (!out_valid && waited < 50) begin
         step();
         waited++;
      end
      c2 = cycle;
      check("b2b_gap", 32'(c2 - c1), 32'(N + 2));
      check("b2b_bits", 32'(out_bits), 32'b0011);
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      step();

      for (int k = 0; k < 800; k++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            int c;
            case ($urandom_range(0, 4))
               0, 1:    c = THR - 40 + int'($urandom_range(0, 80));
               2:       c = int'($urandom);
               3:       c = -32768;
               default: c = 32767;
            endcase
            in_coefs[(N-i)*DW-1 -: DW] = DW'(c);
         end
         rst = ($urandom_range(0, 149) == 0);
         step();
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (N + 4) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
